// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO behind a valid/ready handshake, serialised as
// start + 8 data (LSB first) + optional parity + stop, each bit CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   FULL     = CW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);

    // state | meaning: IDLE line high | START start bit | DATA bits LSB first | PARITY bit | STOP bit
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CNTW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_par;
    logic            r_tx;
    logic            w_tx_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      w_head;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_empty    = (r_count == '0);
    assign data_ready = (r_count != FULL);
    assign w_push     = data_valid && data_ready;
    assign w_bit_end  = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_shift <= w_shift_next;
            if (r_state == S_IDLE || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // parity is captured from the whole byte before the shift register consumes it
            if (w_pop) begin
                r_par <= (PARITY == 2) ? ~^w_head : ^w_head;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && r_bit_idx == 3'd7) begin
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes exactly at bit boundaries
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = w_head;
        end else if (r_state == S_DATA && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_par;
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_count = r_count;
endmodule
